// File: rtl/operand_stage.sv
// Registered multi-lane ALU operand generator with writeback bypass and a one-entry valid/ready holding register.
// Define OPERAND_STAGE_SNOOP_EN to keep stalled REG operands snooping the writeback ports.
module operand_stage #(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int PC_W      = 15,
  parameter int FWD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_en,
  input  logic [LANES*XLEN-1:0]     imm,
  input  logic [LANES*2-1:0]        aluop1_type,
  input  logic [LANES*2-1:0]        aluop2_type,
  input  logic [LANES*PC_W-1:0]     pc,
  input  logic [LANES*5-1:0]        rs1,
  input  logic [LANES*5-1:0]        rs2,
  input  logic [LANES*XLEN-1:0]     reg_data1,
  input  logic [LANES*XLEN-1:0]     reg_data2,
  input  logic [FWD_PORTS-1:0]      fwd_valid,
  input  logic [FWD_PORTS*5-1:0]    fwd_rd,
  input  logic [FWD_PORTS*XLEN-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_en,
  output logic [LANES*XLEN-1:0]     op1,
  output logic [LANES*XLEN-1:0]     op2
);

  localparam logic [1:0] OP_TYPE_REG = 2'd0;
  localparam logic [1:0] OP_TYPE_IMM = 2'd1;
  localparam logic [1:0] OP_TYPE_PC  = 2'd2;

  // Returns {hit, data}; scanning downward lets the lowest-numbered matching port win.
  function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] rs,
                                               input logic [FWD_PORTS-1:0] v,
                                               input logic [FWD_PORTS*5-1:0] rd,
                                               input logic [FWD_PORTS*XLEN-1:0] d);
    logic [XLEN:0] r;
    r = '0;
    for (int p = FWD_PORTS - 1; p >= 0; p--)
      if (rs != 5'd0 && v[p] && rd[p*5 +: 5] == rs) r = {1'b1, d[p*XLEN +: XLEN]};
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sel_op(input logic [1:0] t, input logic [XLEN:0] hit,
                                             input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] imm_v,
                                             input logic [PC_W-1:0] pc_v);
    logic [XLEN-1:0] r;
    case (t)
      OP_TYPE_REG: r = hit[XLEN] ? hit[XLEN-1:0] : rdata;
      OP_TYPE_IMM: r = imm_v;
      OP_TYPE_PC:  r = XLEN'(pc_v);
      default:     r = '0;
    endcase
    return r;
  endfunction

  logic                  valid_q, valid_d;
  logic [LANES-1:0]      lane_en_q, lane_en_d;
  logic [LANES*XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [LANES*XLEN-1:0] ld_op1, ld_op2;
  logic                  load;

`ifdef OPERAND_STAGE_SNOOP_EN
  logic [LANES*5-1:0]    rs1_q, rs1_d, rs2_q, rs2_d;
  logic [LANES-1:0]      reg1_q, reg1_d, reg2_q, reg2_d;
  logic [LANES-1:0]      is_reg1, is_reg2;
  logic [LANES*XLEN-1:0] sn_op1, sn_op2;
`endif

  assign in_ready    = !valid_q || out_ready;
  assign load        = in_valid && in_ready && !flush;
  assign out_valid   = valid_q;
  assign out_lane_en = lane_en_q;
  assign op1         = op1_q;
  assign op2         = op2_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [XLEN:0] hit1, hit2;
    assign hit1 = fwd_lookup(rs1[gi*5 +: 5], fwd_valid, fwd_rd, fwd_data);
    assign hit2 = fwd_lookup(rs2[gi*5 +: 5], fwd_valid, fwd_rd, fwd_data);
    assign ld_op1[gi*XLEN +: XLEN] = sel_op(aluop1_type[gi*2 +: 2], hit1, reg_data1[gi*XLEN +: XLEN],
                                            imm[gi*XLEN +: XLEN], pc[gi*PC_W +: PC_W]);
    assign ld_op2[gi*XLEN +: XLEN] = sel_op(aluop2_type[gi*2 +: 2], hit2, reg_data2[gi*XLEN +: XLEN],
                                            imm[gi*XLEN +: XLEN], pc[gi*PC_W +: PC_W]);
`ifdef OPERAND_STAGE_SNOOP_EN
    logic [XLEN:0] sh1, sh2;
    assign is_reg1[gi] = (aluop1_type[gi*2 +: 2] == OP_TYPE_REG);
    assign is_reg2[gi] = (aluop2_type[gi*2 +: 2] == OP_TYPE_REG);
    assign sh1 = fwd_lookup(rs1_q[gi*5 +: 5], fwd_valid, fwd_rd, fwd_data);
    assign sh2 = fwd_lookup(rs2_q[gi*5 +: 5], fwd_valid, fwd_rd, fwd_data);
    assign sn_op1[gi*XLEN +: XLEN] = (reg1_q[gi] && sh1[XLEN]) ? sh1[XLEN-1:0] : op1_q[gi*XLEN +: XLEN];
    assign sn_op2[gi*XLEN +: XLEN] = (reg2_q[gi] && sh2[XLEN]) ? sh2[XLEN-1:0] : op2_q[gi*XLEN +: XLEN];
`endif
  end

  always_comb begin
    valid_d   = valid_q;
    lane_en_d = lane_en_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
`ifdef OPERAND_STAGE_SNOOP_EN
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    reg1_d = reg1_q;
    reg2_d = reg2_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      lane_en_d = in_lane_en;
      op1_d     = ld_op1;
      op2_d     = ld_op2;
`ifdef OPERAND_STAGE_SNOOP_EN
      rs1_d  = rs1;
      rs2_d  = rs2;
      reg1_d = is_reg1;
      reg2_d = is_reg2;
`endif
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
`ifdef OPERAND_STAGE_SNOOP_EN
      // Stalled: pick up writebacks that arrive after the operands were loaded.
      op1_d = sn_op1;
      op2_d = sn_op2;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      lane_en_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
`ifdef OPERAND_STAGE_SNOOP_EN
      rs1_q  <= '0;
      rs2_q  <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
`endif
    end else begin
      valid_q   <= valid_d;
      lane_en_q <= lane_en_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
`ifdef OPERAND_STAGE_SNOOP_EN
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
`endif
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed vector table, hand-written stall/flush/reset
// sequences, and randomized traffic against a behavioural model of the operand rules.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  in_lane_en, out_lane_en, fwd_valid;
  logic [63:0] imm, reg_data1, reg_data2, fwd_data, op1, op2;
  logic [3:0]  aluop1_type, aluop2_type;
  logic [29:0] pc;
  logic [9:0]  rs1, rs2, fwd_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_stage #(.LANES(2), .XLEN(32), .PC_W(15), .FWD_PORTS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
    .imm(imm), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type), .pc(pc),
    .rs1(rs1), .rs2(rs2), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en), .op1(op1), .op2(op2)
  );

  typedef struct {
    logic [1:0]  en;
    logic [3:0]  t1, t2;
    logic [9:0]  r1, r2;
    logic [63:0] d1, d2, im;
    logic [29:0] p;
    logic [1:0]  fv;
    logic [9:0]  frd;
    logic [63:0] fd;
    logic [63:0] e1, e2;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  // Behavioural model state: one held bundle.
  logic        m_valid;
  logic [1:0]  m_en;
  logic [31:0] m_op1[2], m_op2[2];
  logic [4:0]  m_rs1[2], m_rs2[2];
  logic        m_r1[2], m_r2[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] en, logic [3:0] t1, logic [3:0] t2, logic [9:0] r1, logic [9:0] r2,
                              logic [63:0] d1, logic [63:0] d2, logic [63:0] im, logic [29:0] p,
                              logic [1:0] fv, logic [9:0] frd, logic [63:0] fd, logic [63:0] e1, logic [63:0] e2);
    vec_t v;
    v.en = en; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2; v.im = im; v.p = p;
    v.fv = fv; v.frd = frd; v.fd = fd; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic idle();
    rst = 0; in_valid = 0; flush = 0; out_ready = 0; in_lane_en = 2'b11; imm = '0;
    aluop1_type = 4'hF; aluop2_type = 4'hF; pc = '0; rs1 = '0; rs2 = '0;
    reg_data1 = '0; reg_data2 = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  // First valid port (lowest index) whose rd equals a non-zero rs.
  function automatic logic [32:0] ref_fwd(logic [4:0] rs);
    for (int p = 0; p < 2; p++)
      if (rs != 0 && fwd_valid[p] && fwd_rd[p*5 +: 5] == rs) return {1'b1, fwd_data[p*32 +: 32]};
    return 33'd0;
  endfunction

  function automatic logic [31:0] ref_operand(logic [1:0] t, logic [4:0] rs, logic [31:0] rdv,
                                              logic [31:0] immv, logic [14:0] pcv);
    logic [32:0] h;
    if (t == 2'd1) return immv;
    if (t == 2'd2) return {17'd0, pcv};
    if (t != 2'd0) return 32'd0;
    h = ref_fwd(rs);
    return h[32] ? h[31:0] : rdv;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_en = 0;
    for (int l = 0; l < 2; l++) begin
      m_op1[l] = 0; m_op2[l] = 0; m_rs1[l] = 0; m_rs2[l] = 0; m_r1[l] = 0; m_r2[l] = 0;
    end
  endtask

  task automatic model_step();
    logic        rdy;
    logic [32:0] h;
    rdy = !m_valid || out_ready;
    if (rst) model_reset();
    else if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1; m_en = in_lane_en;
      for (int l = 0; l < 2; l++) begin
        m_op1[l] = ref_operand(aluop1_type[l*2 +: 2], rs1[l*5 +: 5], reg_data1[l*32 +: 32], imm[l*32 +: 32], pc[l*15 +: 15]);
        m_op2[l] = ref_operand(aluop2_type[l*2 +: 2], rs2[l*5 +: 5], reg_data2[l*32 +: 32], imm[l*32 +: 32], pc[l*15 +: 15]);
        m_rs1[l] = rs1[l*5 +: 5]; m_rs2[l] = rs2[l*5 +: 5];
        m_r1[l] = (aluop1_type[l*2 +: 2] == 2'd0); m_r2[l] = (aluop2_type[l*2 +: 2] == 2'd0);
      end
    end else if (m_valid && out_ready) m_valid = 0;
    else if (m_valid) begin
`ifdef OPERAND_STAGE_SNOOP_EN
      for (int l = 0; l < 2; l++) begin
        h = ref_fwd(m_rs1[l]);
        if (m_r1[l] && h[32]) m_op1[l] = h[31:0];
        h = ref_fwd(m_rs2[l]);
        if (m_r2[l] && h[32]) m_op2[l] = h[31:0];
      end
`else
      h = 33'd0;
`endif
    end
  endtask

  initial begin
    logic [31:0] exp_stall;
    vecs[0] = mk(2'b11, 4'b1000, 4'b1101, {5'd0, 5'd5}, '0, {32'h0, 32'hDEAD0005}, '0, {32'h0, 32'h10},
                 {15'h1234, 15'h0}, 2'b00, '0, '0, {32'h1234, 32'hDEAD0005}, {32'h0, 32'h10});
    vecs[1] = mk(2'b11, 4'b0000, 4'b1111, {5'd7, 5'd7}, '0, {32'h2, 32'h11111111}, '0, '0, '0,
                 2'b11, {5'd7, 5'd7}, {32'hBBBB, 32'hAAAA}, {32'hAAAA, 32'hAAAA}, 64'h0);
    vecs[2] = mk(2'b10, 4'b0100, 4'b1000, '0, '0, {32'h0, 32'h12345678}, {32'h0, 32'h22}, {32'h77, 32'h0},
                 {15'h7FFF, 15'h0}, 2'b11, '0, {32'hCCCC, 32'hDDDD}, {32'h77, 32'h12345678}, {32'h7FFF, 32'h22});
    vecs[3] = mk(2'b01, 4'b0000, 4'b0000, {5'd3, 5'd7}, {5'd3, 5'd4}, '0, {32'h0, 32'h44}, '0, '0,
                 2'b11, {5'd7, 5'd3}, {32'hBBBB, 32'hAAAA}, {32'hAAAA, 32'hBBBB}, {32'hAAAA, 32'h44});
    vecs[4] = mk(2'b11, 4'b0000, 4'b0000, {5'd0, 5'd7}, {5'd6, 5'd6}, {32'h3, 32'h9}, {32'h5, 32'h6}, '0, '0,
                 2'b10, {5'd7, 5'd7}, {32'hBBBB, 32'hAAAA}, {32'h3, 32'hBBBB}, {32'h5, 32'h6});

    idle();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0; #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_op1", op1, 64'd0);
    chk("reset_op2", op2, 64'd0);
    chk("reset_lane_en", {62'd0, out_lane_en}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    $display("reset: out_valid=%0b in_ready=%0b op1=%h op2=%h", out_valid, in_ready, op1, op2);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      idle();
      in_valid = 1; out_ready = 1;
      in_lane_en = vecs[i].en; aluop1_type = vecs[i].t1; aluop2_type = vecs[i].t2;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2; reg_data1 = vecs[i].d1; reg_data2 = vecs[i].d2;
      imm = vecs[i].im; pc = vecs[i].p; fwd_valid = vecs[i].fv; fwd_rd = vecs[i].frd; fwd_data = vecs[i].fd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_lane_en", i), {62'd0, out_lane_en}, {62'd0, vecs[i].en});
      chk($sformatf("vec%0d_op1", i), op1, vecs[i].e1);
      chk($sformatf("vec%0d_op2", i), op2, vecs[i].e2);
      $display("vec %0d: op1=%h op2=%h lane_en=%b", i, op1, op2, out_lane_en);
    end

    // Stall with a late writeback on port 1.
    @(negedge clk);
    idle();
    in_valid = 1; out_ready = 1;
    aluop2_type = 4'b1100; rs2 = {5'd0, 5'd9}; reg_data2 = {32'h0, 32'h99};
    @(negedge clk);
    idle();
    @(negedge clk);
    fwd_valid = 2'b10; fwd_rd = {5'd9, 5'd0}; fwd_data = {32'h55, 32'h0};
    @(negedge clk);
    idle();
    @(negedge clk);
`ifdef OPERAND_STAGE_SNOOP_EN
    exp_stall = 32'h55;
`else
    exp_stall = 32'h99;
`endif
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_op2", {32'd0, op2[31:0]}, {32'd0, exp_stall});
    $display("stall: op2[0]=%h", op2[31:0]);
    out_ready = 1;
    @(posedge clk); #1;
    chk("stall_consumed", {63'd0, out_valid}, 64'd0);

    // Back-to-back bundles.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      in_valid = 1; out_ready = 1; aluop1_type = 4'b0101;
      imm = {32'(k), 32'h100 + 32'(k)};
      #1;
      chk($sformatf("b2b%0d_in_ready", k), {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("b2b%0d_op1", k), op1, {32'(k), 32'h100 + 32'(k)});
      $display("b2b %0d: op1=%h", k, op1);
    end

    // Flush while full with an incoming bundle.
    @(negedge clk);
    idle();
    in_valid = 1; flush = 1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("flush_dropped", {63'd0, out_valid}, 64'd0);
    $display("flush: out_valid=%0b", out_valid);

    // Reset in the middle of a stall.
    @(negedge clk);
    idle();
    in_valid = 1; aluop1_type = 4'b0101; aluop2_type = 4'b1010; imm = 64'hFFFF_0001_FFFF_0002; pc = 30'h3FFF_FFFF;
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_op1", op1, 64'd0);
    chk("rst_mid_op2", op2, 64'd0);
    chk("rst_mid_lane_en", {62'd0, out_lane_en}, 64'd0);
    $display("rst mid-stall: op1=%h op2=%h", op1, op2);

    // Randomized traffic against the model.
    @(negedge clk);
    idle();
    rst = 1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("rnd_lane_en", {62'd0, out_lane_en}, {62'd0, m_en});
        chk("rnd_op1", op1, {m_op1[1], m_op1[0]});
        chk("rnd_op2", op2, {m_op2[1], m_op2[0]});
      end
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_lane_en = 2'($urandom);
      aluop1_type = 4'($urandom); aluop2_type = 4'($urandom);
      for (int l = 0; l < 2; l++) begin
        rs1[l*5 +: 5] = 5'($urandom_range(0, 3));
        rs2[l*5 +: 5] = 5'($urandom_range(0, 3));
        fwd_rd[l*5 +: 5] = 5'($urandom_range(0, 3));
        imm[l*32 +: 32] = $urandom; reg_data1[l*32 +: 32] = $urandom;
        reg_data2[l*32 +: 32] = $urandom; fwd_data[l*32 +: 32] = $urandom;
      end
      pc = 30'($urandom);
      fwd_valid = 2'($urandom);
      #1;
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Registered, multi-lane ALU operand generator for the superscalar core. Each lane selects op1/op2 from register-file data, immediate, zero-extended PC, or zero. REG-type operands are bypassed from up to FWD_PORTS writeback ports. The selected operands are held in a one-entry valid/ready pipeline register between decode/issue and the ALUs. While a bundle is stalled in the register, REG operands keep snooping the writeback ports so late results are not lost.

## Interface
Parameters:
- LANES, 2, issue lanes per bundle
- XLEN, 32, operand width
- PC_W, 15, PC width, zero-extended to XLEN
- FWD_PORTS, 2, writeback/bypass ports; index 0 is highest priority (youngest)

Ports (lane/port k occupies slice [k*W +: W]):
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  synchronous, active-high reset
- Upstream bundle:
  - in_valid  in  1  upstream bundle valid
  - in_ready  out  1  stage can accept a bundle
  - in_lane_en  in  LANES  per-lane occupancy
  - imm  in  LANES*XLEN  immediates
  - aluop1_type, aluop2_type  in  LANES*2  operand type codes
  - pc  in  LANES*PC_W  lane PCs
  - rs1, rs2  in  LANES*5  source register indices
  - reg_data1, reg_data2  in  LANES*XLEN  register-file read data
- Bypass:
  - fwd_valid  in  FWD_PORTS  bypass port valid
  - fwd_rd  in  FWD_PORTS*5  bypass destination index
  - fwd_data  in  FWD_PORTS*XLEN  bypass data
- Control:
  - flush  in  1  kill held bundle and any incoming bundle
- Downstream bundle:
  - out_valid  out  1  bundle held for ALUs
  - out_ready  in  1  ALUs consume bundle
  - out_lane_en  out  LANES  registered in_lane_en
  - op1, op2  out  LANES*XLEN  registered operands

## Operation
- Operand select per lane and operand:
  - OP_TYPE_REG: bypassed register data.
  - OP_TYPE_IMM: imm.
  - OP_TYPE_PC: {zeros, pc}.
  - Any other code: 0.
  - Type codes are the core's shared OP_TYPE_* defines.
- Bypass:
  - Applies only to OP_TYPE_REG operands with rs != 0.
  - Candidate ports: fwd_valid[p] && fwd_rd[p] == rs.
  - The lowest matching p wins. With no match, reg_data is used.
  - fwd_rd == 0 never forwards.
- Register state: out_valid, out_lane_en, op1, op2, plus stored rs1/rs2 and REG-type flags per lane for snooping.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY, in_valid && !flush → FULL, load bundle.
  - FULL, out_ready && in_valid && !flush → FULL, load new bundle (back-to-back).
  - FULL, out_ready && !in_valid → EMPTY.
  - FULL, !out_ready → FULL, hold. REG operands with a matching snoop hit are overwritten with the winning fwd_data; all other fields hold.
  - flush in any state → EMPTY next cycle; the incoming bundle is dropped.
- Disabled lanes (in_lane_en=0) still load operands; downstream ignores them via out_lane_en.

## Timing
- Reset: out_valid=0, out_lane_en=0, op1=0, op2=0, stored rs and flags = 0.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: one bundle per cycle.
- in_ready = !out_valid || out_ready, combinational. It does not depend on flush.
- Handshake: input is accepted on in_valid && in_ready. Output is consumed on out_valid && out_ready.
- Snoop and load use the fwd_* values of the same cycle. A writeback in the cycle of acceptance is captured directly.
- Simultaneous flush and rst: rst wins, with the same effect.

## Configuration
- OPERAND_STAGE_SNOOP_EN
  - Defined: held REG operands are updated from the fwd ports while stalled, as described above.
  - Undefined: held operands are frozen after load, and the stored rs/flag registers are not built. Issue logic must then block dependent bundles until writeback reaches the register file.

## Test plan
- Reset → out_valid=0, op1=op2=0, in_ready=1.
- Lane0 op1 REG with rs1=5, op2 IMM with imm=0x10. Lane1 op1 PC with pc=0x1234, op2 code 3. No fwd → next cycle op1[0]=reg_data1, op2[0]=0x10, op1[1]=0x00001234, op2[1]=0.
- rs1=7 with fwd_valid=2'b11, fwd_rd={7,7}, fwd_data={0xBBBB,0xAAAA} → op1=0xAAAA (port 0 wins). rs1=0 with fwd_rd=0 → reg_data1 is used.
- Load rs2=9 REG, hold out_ready=0 for 3 cycles, pulse fwd port1 rd=9 data=0x55 in cycle 2.
  - With the macro defined: op2=0x55 when consumed.
  - With the macro undefined: op2 stays at the loaded value.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles → 4 bundles out in order, in_ready stays 1.
- flush while FULL with in_valid=1 → out_valid=0 next cycle, incoming bundle dropped. rst mid-stall → all outputs 0 next cycle.
